// File: rtl/div_unit_if.sv
// div_unit_if -- handshake/operand bundle between the execute stage and the
// multi-cycle divider.
//
// Signals (named from the divider's point of view):
//   signed_div_i  1 = signed DIV, 0 = unsigned DIVU
//   opdata1_i     dividend (WIDTH bits)
//   opdata2_i     divisor  (WIDTH bits)
//   start_i       request, held by EX until the result is taken
//   annul_i       abort an in-flight division
//   result_o      {remainder, quotient} (2*WIDTH bits)
//   ready_o       result_o valid
//
// Modports:
//   master  execute stage (drives request and operands)
//   slave   divider (drives result and ready)
interface div_unit_if #(
  parameter int WIDTH = 32
);
  logic                 signed_div_i;
  logic [WIDTH-1:0]     opdata1_i;
  logic [WIDTH-1:0]     opdata2_i;
  logic                 start_i;
  logic                 annul_i;
  logic [2*WIDTH-1:0]   result_o;
  logic                 ready_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o
  );
endinterface

// File: rtl/div_unit.sv
// div_unit -- multi-cycle restoring integer divider for the execute stage.
// Produces {remainder, quotient} for the HI/LO write, one quotient bit per
// clock. Signed division works on magnitudes and fixes signs at the end.
//
// Ports:
//   clk     rising-edge clock
//   rst     synchronous reset, active-high
//   io_bus  div_unit_if.slave: operands, start/annul request, result/ready
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst,
  div_unit_if.slave    io_bus
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH);

  localparam logic [1:0] S_FREE   = 2'd0;
  localparam logic [1:0] S_BYZERO = 2'd1;
  localparam logic [1:0] S_ON     = 2'd2;
  localparam logic [1:0] S_END    = 2'd3;

  // Two's complement negation; the most negative value maps to itself,
  // which is the correct unsigned magnitude.
  function automatic logic [WIDTH-1:0] f_twos(input logic [WIDTH-1:0] x);
    return ~x + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  logic [1:0]           r_state;
  logic [CW-1:0]        r_cnt;
  logic [WIDTH-1:0]     r_quo;      // dividend shifts out, quotient shifts in
  logic [WIDTH-1:0]     r_rem;
  logic [WIDTH-1:0]     r_divisor;
  logic                 r_neg_q;
  logic                 r_neg_r;
  logic [2*WIDTH-1:0]   r_result;
  logic                 r_ready;

  logic [WIDTH-1:0]     w_abs_a;
  logic [WIDTH-1:0]     w_abs_b;
  logic [WIDTH:0]       w_shifted;
  logic [WIDTH:0]       w_partial;
  logic [WIDTH-1:0]     w_next_rem;
  logic [WIDTH-1:0]     w_next_quo;
  logic [WIDTH-1:0]     w_fix_quo;
  logic [WIDTH-1:0]     w_fix_rem;
  logic                 w_sign_a;
  logic                 w_sign_b;

  assign w_sign_a = io_bus.opdata1_i[WIDTH-1];
  assign w_sign_b = io_bus.opdata2_i[WIDTH-1];

  // Operand magnitudes captured at start (raw values for unsigned).
  always_comb begin
    w_abs_a = io_bus.opdata1_i;
    w_abs_b = io_bus.opdata2_i;
    if (io_bus.signed_div_i && w_sign_a) begin
      w_abs_a = f_twos(io_bus.opdata1_i);
    end else begin
      w_abs_a = io_bus.opdata1_i;
    end
    if (io_bus.signed_div_i && w_sign_b) begin
      w_abs_b = f_twos(io_bus.opdata2_i);
    end else begin
      w_abs_b = io_bus.opdata2_i;
    end
  end

  // One restoring step: the top bit of the borrow tells if the trial
  // subtraction went negative.
  always_comb begin
    w_shifted  = {r_rem, r_quo[WIDTH-1]};
    w_partial  = w_shifted - {1'b0, r_divisor};
    w_next_rem = w_shifted[WIDTH-1:0];
    w_next_quo = {r_quo[WIDTH-2:0], 1'b0};
    if (!w_partial[WIDTH]) begin
      w_next_rem = w_partial[WIDTH-1:0];
      w_next_quo = {r_quo[WIDTH-2:0], 1'b1};
    end else begin
      w_next_rem = w_shifted[WIDTH-1:0];
      w_next_quo = {r_quo[WIDTH-2:0], 1'b0};
    end
  end

  // Sign restoration of the final magnitudes.
  always_comb begin
    w_fix_quo = r_quo;
    w_fix_rem = r_rem;
    if (r_neg_q) begin
      w_fix_quo = f_twos(r_quo);
    end else begin
      w_fix_quo = r_quo;
    end
    if (r_neg_r) begin
      w_fix_rem = f_twos(r_rem);
    end else begin
      w_fix_rem = r_rem;
    end
  end

  // Control FSM and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_FREE;
      r_cnt     <= {CW{1'b0}};
      r_quo     <= {WIDTH{1'b0}};
      r_rem     <= {WIDTH{1'b0}};
      r_divisor <= {WIDTH{1'b0}};
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_result  <= {(2*WIDTH){1'b0}};
      r_ready   <= 1'b0;
    end else begin
      case (r_state)
        S_FREE: begin
          r_ready  <= 1'b0;
          r_result <= {(2*WIDTH){1'b0}};
          if (io_bus.start_i && !io_bus.annul_i) begin
            if (io_bus.opdata2_i == {WIDTH{1'b0}}) begin
              r_state <= S_BYZERO;
            end else begin
              r_state   <= S_ON;
              r_quo     <= w_abs_a;
              r_rem     <= {WIDTH{1'b0}};
              r_divisor <= w_abs_b;
              r_neg_q   <= io_bus.signed_div_i & (w_sign_a ^ w_sign_b);
              r_neg_r   <= io_bus.signed_div_i & w_sign_a;
              r_cnt     <= {CW{1'b0}};
            end
          end
        end
        S_BYZERO: begin
          r_result <= {(2*WIDTH){1'b0}};
          r_ready  <= 1'b0;
          if (io_bus.annul_i) begin
            r_state <= S_FREE;
          end else begin
            r_state <= S_END;
          end
        end
        S_ON: begin
          if (io_bus.annul_i) begin
            r_state  <= S_FREE;
            r_ready  <= 1'b0;
            r_result <= {(2*WIDTH){1'b0}};
            r_cnt    <= {CW{1'b0}};
          end else if (r_cnt == CNT_LAST) begin
            r_state  <= S_END;
            r_result <= {w_fix_rem, w_fix_quo};
            r_ready  <= 1'b1;
          end else begin
            r_rem <= w_next_rem;
            r_quo <= w_next_quo;
            r_cnt <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
          end
        end
        S_END: begin
          // The divide-by-zero path arrives with ready low and raises it
          // here, so every result is presented for at least one cycle.
          if (io_bus.annul_i) begin
            r_state  <= S_FREE;
            r_ready  <= 1'b0;
            r_result <= {(2*WIDTH){1'b0}};
          end else if (!r_ready) begin
            r_ready <= 1'b1;
          end else if (!io_bus.start_i) begin
            r_state  <= S_FREE;
            r_ready  <= 1'b0;
            r_result <= {(2*WIDTH){1'b0}};
          end else begin
            r_ready <= 1'b1;
          end
        end
        default: begin
          r_state  <= S_FREE;
          r_ready  <= 1'b0;
          r_result <= {(2*WIDTH){1'b0}};
          r_cnt    <= {CW{1'b0}};
        end
      endcase
    end
  end

  assign io_bus.result_o = r_result;
  assign io_bus.ready_o  = r_ready;

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit -- directed and randomized checks of div_unit against a
// plain-arithmetic reference model (64-bit signed division, truncating
// toward zero, remainder takes the dividend's sign).
module tb_div_unit;

  logic clk = 1'b0;
  logic rst;
  int   n_pass  = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  div_unit_if #(.WIDTH(32)) bus ();

  div_unit #(.WIDTH(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [63:0] ref_div(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (sgn) begin
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
    end else begin
      sa = {32'd0, a};
      sb = {32'd0, b};
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Issue one division starting right after an edge; check latency, result,
  // extra held cycles, and the drop back to idle.
  task automatic do_div(input string tag, input bit sgn, input logic [31:0] a,
                        input logic [31:0] b, input int hold, input bit scramble);
    logic [63:0] exp;
    int n;
    exp = ref_div(sgn, a, b);
    bus.signed_div_i = sgn;
    bus.opdata1_i    = a;
    bus.opdata2_i    = b;
    bus.annul_i      = 1'b0;
    bus.start_i      = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      if (scramble && n == 5) begin
        bus.opdata1_i    = $urandom;
        bus.opdata2_i    = $urandom;
        bus.signed_div_i = ~sgn;
      end
    end while (bus.ready_o !== 1'b1 && n < 40);
    check({tag, " latency"}, 64'(n), (b == 32'd0) ? 64'd3 : 64'd34);
    check({tag, " result"}, bus.result_o, exp);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, " hold ready"}, 64'(bus.ready_o), 64'd1);
      check({tag, " hold result"}, bus.result_o, exp);
    end
    bus.start_i = 1'b0;
    @(posedge clk); #1;
    check({tag, " drop ready"}, 64'(bus.ready_o), 64'd0);
    check({tag, " drop result"}, bus.result_o, 64'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int seen_ready;
    bit sgn;
    logic [31:0] a, b;

    rst              = 1'b1;
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd0;
    bus.opdata2_i    = 32'd0;
    bus.start_i      = 1'b0;
    bus.annul_i      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset ready", 64'(bus.ready_o), 64'd0);
    check("reset result", bus.result_o, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    do_div("divu_100_7", 1'b0, 32'd100, 32'd7, 0, 1'b0);
    do_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 0, 1'b0);
    do_div("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 0, 1'b0);
    do_div("divu_by0", 1'b0, 32'h0000_1234, 32'd0, 0, 1'b0);
    do_div("div_by0", 1'b1, 32'h0000_1234, 32'd0, 1, 1'b0);

    // Annul at edge 10 (edge 0 samples start).
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd100;
    bus.opdata2_i    = 32'd7;
    bus.start_i      = 1'b1;
    repeat (10) begin @(posedge clk); #1; end
    bus.annul_i = 1'b1;
    bus.start_i = 1'b0;
    @(posedge clk); #1;
    bus.annul_i = 1'b0;
    seen_ready = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.ready_o !== 1'b0) seen_ready++;
    end
    check("annul no ready", 64'(seen_ready), 64'd0);
    do_div("divu_9_3", 1'b0, 32'd9, 32'd3, 0, 1'b0);

    // Reset at edge 20 of a running division.
    bus.signed_div_i = 1'b1;
    bus.opdata1_i    = 32'd100;
    bus.opdata2_i    = 32'd7;
    bus.start_i      = 1'b1;
    repeat (20) begin @(posedge clk); #1; end
    rst         = 1'b1;
    bus.start_i = 1'b0;
    @(posedge clk); #1;
    check("midrst ready", 64'(bus.ready_o), 64'd0);
    check("midrst result", bus.result_o, 64'd0);
    rst = 1'b0;
    do_div("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
    do_div("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, 0, 1'b0);
    do_div("scramble_hold", 1'b1, 32'hFFFF_8000, 32'd1234, 5, 1'b1);

    for (int k = 0; k < 16; k++) begin
      sgn = 1'($urandom_range(0, 1));
      a   = $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = 32'hFFFF_FFFF;
        3:       begin a = 32'h8000_0000; b = $urandom; end
        default: b = $urandom;
      endcase
      do_div("random", sgn, a, b, $urandom_range(0, 2), 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
